// File: rtl/ms_neighbor_scan.sv
// Board sweep after mine placement: for every cell, read the 8 neighbouring mine bits
// and write the resulting 0..8 count into the count RAM, in raster order.
module ms_neighbor_scan #(
  parameter int unsigned ROWS = 16,
  parameter int unsigned COLS = 16,
  parameter int unsigned RB   = 4,
  parameter int unsigned CB   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          mine_rd_en,
  output logic [RB-1:0] mine_row,
  output logic [CB-1:0] mine_col,
  input  logic          mine_q,
  output logic          cnt_we,
  output logic [RB-1:0] cnt_row,
  output logic [CB-1:0] cnt_col,
  output logic [3:0]    cnt_data
);

  localparam int unsigned KW = 4;
  localparam int unsigned AW = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_FLUSH,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [RB-1:0] r_row;
  logic [CB-1:0] r_col;
  logic [KW-1:0] r_k;
  logic [AW-1:0] r_acc;
  logic          r_vld;

  logic          r_busy;
  logic          r_done;
  logic          r_rd_en;
  logic [RB-1:0] r_mine_row;
  logic [CB-1:0] r_mine_col;
  logic          r_cnt_we;
  logic [RB-1:0] r_cnt_row;
  logic [CB-1:0] r_cnt_col;
  logic [AW-1:0] r_cnt_data;

  logic [1:0]    w_dr_idx;
  logic [1:0]    w_dc_idx;
  logic [KW-1:0] w_k_base;
  logic [RB:0]   w_row_ext;
  logic [CB:0]   w_col_ext;
  logic          w_rd_ok;
  logic [AW-1:0] w_acc_next;
  logic          w_last_col;
  logic          w_last_row;

  // k -> (dr+1, dc+1): k/3 and k%3 without a divider
  assign w_dr_idx = (r_k < KW'(3)) ? 2'd0 : (r_k < KW'(6)) ? 2'd1 : 2'd2;
  assign w_k_base = (r_k < KW'(3)) ? KW'(0) : (r_k < KW'(6)) ? KW'(3) : KW'(6);
  assign w_dc_idx = 2'(r_k - w_k_base);

  // One bit wider so that -1 lands far above the board instead of aliasing to the far edge
  assign w_row_ext = (RB+1)'(r_row) + (RB+1)'(w_dr_idx) - (RB+1)'(1);
  assign w_col_ext = (CB+1)'(r_col) + (CB+1)'(w_dc_idx) - (CB+1)'(1);
  assign w_rd_ok   = (r_k != KW'(4)) && (w_row_ext < (RB+1)'(ROWS))
                     && (w_col_ext < (CB+1)'(COLS));

  assign w_acc_next = r_vld ? (r_acc + AW'(mine_q)) : r_acc;
  assign w_last_col = (r_col == CB'(COLS - 1));
  assign w_last_row = (r_row == RB'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_vld      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_mine_row <= '0;
      r_mine_col <= '0;
      r_cnt_we   <= 1'b0;
      r_cnt_row  <= '0;
      r_cnt_col  <= '0;
      r_cnt_data <= '0;
    end else begin
      r_rd_en  <= 1'b0;
      r_cnt_we <= 1'b0;
      r_done   <= 1'b0;
      r_vld    <= r_rd_en;
      r_acc    <= w_acc_next;
      case (r_state)
        S_IDLE: begin
          // A start seen while the done pulse is still out waits one more cycle
          if (start && !r_done) begin
            r_state <= S_SCAN;
            r_row   <= '0;
            r_col   <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_SCAN: begin
          r_rd_en    <= w_rd_ok;
          r_mine_row <= w_row_ext[RB-1:0];
          r_mine_col <= w_col_ext[CB-1:0];
          if (r_k == KW'(8)) begin
            r_k     <= '0;
            r_state <= S_FLUSH;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        S_FLUSH: begin
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_cnt_we   <= 1'b1;
          r_cnt_row  <= r_row;
          r_cnt_col  <= r_col;
          r_cnt_data <= w_acc_next;
          r_acc      <= '0;
          r_k        <= '0;
          if (w_last_col) begin
            r_col <= '0;
            r_row <= w_last_row ? '0 : (r_row + RB'(1));
          end else begin
            r_col <= r_col + CB'(1);
          end
          r_state <= (w_last_col && w_last_row) ? S_DONE : S_SCAN;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_row   <= '0;
          r_col   <= '0;
          r_k     <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign mine_rd_en = r_rd_en;
  assign mine_row   = r_mine_row;
  assign mine_col   = r_mine_col;
  assign cnt_we     = r_cnt_we;
  assign cnt_row    = r_cnt_row;
  assign cnt_col    = r_cnt_col;
  assign cnt_data   = r_cnt_data;

endmodule
